// File: rtl/patch_loader_pkg.sv
// Shared accelerator definitions for the patch loader: FSM encoding, patch size, counter width.
package patch_loader_pkg;

  localparam int PL_NWORDS = 32;
  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PL_NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } pl_state_t;

endpackage

// File: rtl/patch_buf.sv
// Patch storage: NWORDS x DW registers with a single write port and a flat read-out.
module patch_buf #(
  parameter int DW     = 8,
  parameter int NWORDS = 32,
  parameter int IW     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [DW-1:0]        wr_data,
  output logic [NWORDS*DW-1:0] rd_data
);

  logic [DW-1:0] words [NWORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      words[wr_idx] <= wr_data;
    end
  end

  for (genvar k = 0; k < NWORDS; k++) begin : g_flat
    assign rd_data[k*DW +: DW] = words[k];
  end

endmodule

// File: rtl/patch_loader.sv
// Collects 32 literal words from an upstream stream into one patch and hands it downstream.
module patch_loader
  import patch_loader_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NWORDS = PL_NWORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 s_valid,
  input  logic [DW-1:0]        s_data,
  output logic                 s_ready,
  output logic                 patch_valid,
  input  logic                 patch_ready,
  output logic [NWORDS*DW-1:0] patch_data,
  output logic [CNT_W-1:0]     load_cnt,
  output logic                 busy,
  output logic                 load_done
);

  pl_state_t state, state_nxt;
  logic      wr_en;
  logic      last_word;
  logic      handoff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last_word = (load_cnt == LAST_IDX);
  assign handoff   = (state == FULL) && patch_ready;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = LOAD;
        LOAD: if (s_valid && last_word) state_nxt = FULL;
        FULL: if (patch_ready) state_nxt = start ? LOAD : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // s_ready is a pure state decode; abort suppresses the write itself instead.
  always_comb begin
    s_ready     = (state == LOAD);
    patch_valid = (state == FULL);
    busy        = (state != IDLE);
    wr_en       = (state == LOAD) && s_valid && !abort;
    load_done   = wr_en && last_word;
  end

  // The count saturates at the last index so FULL reports 31 until handoff clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
    end else if (abort) begin
      load_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      load_cnt <= '0;
    end else if (wr_en && !last_word) begin
      load_cnt <= load_cnt + 1'b1;
    end else if (handoff) begin
      load_cnt <= '0;
    end
  end

  patch_buf #(
    .DW     (DW),
    .NWORDS (NWORDS),
    .IW     (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (load_cnt),
    .wr_data (s_data),
    .rd_data (patch_data)
  );

endmodule

// File: tb/tb_patch_loader.sv
// Directed self-checking bench for patch_loader with a bench-side copy of the expected buffer.
module tb_patch_loader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         s_valid;
  logic [7:0]   s_data;
  logic         s_ready;
  logic         patch_valid;
  logic         patch_ready;
  logic [255:0] patch_data;
  logic [4:0]   load_cnt;
  logic         busy;
  logic         load_done;

  logic [255:0] exp_buf;
  int           total;
  int           bad;
  int           xfer_cnt;
  int           xfer_mark;

  patch_loader #(.DW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .patch_valid (patch_valid),
    .patch_ready (patch_ready),
    .patch_data  (patch_data),
    .load_cnt    (load_cnt),
    .busy        (busy),
    .load_done   (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts words the DUT actually takes, to prove no 33rd word slips in.
  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready && !abort) xfer_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic sv,
                               input logic [7:0] sd, input logic pr);
    start       = st;
    abort       = ab;
    s_valid     = sv;
    s_data      = sd;
    patch_ready = pr;
    #1;
  endtask

  task automatic loadWords(input logic [7:0] base, input int n, input bit gaps, input logic hold_start);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        applyStimulus(hold_start, 1'b0, 1'b0, 8'hEE, 1'b0);
        checkOutput("stall_cnt", 256'(load_cnt), 256'(k));
        @(negedge clk);
      end
      applyStimulus(hold_start, 1'b0, 1'b1, 8'(base + k), 1'b0);
      checkOutput("load_cnt", 256'(load_cnt), 256'(k));
      checkOutput("load_done", 256'(load_done), 256'(k == 31));
      exp_buf[k*8 +: 8] = 8'(base + k);
      @(negedge clk);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
    checkOutput({tag, "_pvalid"}, 256'(patch_valid), 256'(0));
    checkOutput({tag, "_sready"}, 256'(s_ready), 256'(0));
    checkOutput({tag, "_cnt"}, 256'(load_cnt), 256'(0));
  endtask

  task automatic checkFull(input string tag);
    checkOutput({tag, "_pvalid"}, 256'(patch_valid), 256'(1));
    checkOutput({tag, "_sready"}, 256'(s_ready), 256'(0));
    checkOutput({tag, "_cnt"}, 256'(load_cnt), 256'(31));
    checkOutput({tag, "_data"}, patch_data, exp_buf);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    xfer_cnt = 0;
    exp_buf  = '0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("reset");
    checkOutput("reset_done", 256'(load_done), 256'(0));
    checkOutput("reset_data", patch_data, 256'(0));

    // Back-to-back load with immediate handoff.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("t1_sready", 256'(s_ready), 256'(1));
    checkOutput("t1_busy", 256'(busy), 256'(1));
    loadWords(8'h00, 32, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkFull("t1_full");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("t1_after");

    // Gapped load, then hold FULL with a 33rd word and a stray start on offer.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    xfer_mark = xfer_cnt;
    loadWords(8'h00, 32, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 4, 1'b0, 1'b1, 8'hFF, 1'b0);
      checkFull("t2_hold");
      @(negedge clk);
    end
    checkOutput("t2_xfers", 256'(xfer_cnt - xfer_mark), 256'(32));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("t2_after");

    // Abort at load_cnt 17: the aborting word must not be written.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    loadWords(8'h60, 17, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    checkOutput("t3_cnt17", 256'(load_cnt), 256'(17));
    checkOutput("t3_done", 256'(load_done), 256'(0));
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("t3_abort");
    checkOutput("t3_retained", patch_data, exp_buf);

    // Fresh load, then handoff with start straight into the next patch.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    loadWords(8'h20, 32, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkFull("t3_full");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t4_sready", 256'(s_ready), 256'(1));
    checkOutput("t4_cnt", 256'(load_cnt), 256'(0));
    checkOutput("t4_pvalid", 256'(patch_valid), 256'(0));
    loadWords(8'hA0, 32, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    checkFull("t4_full");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("t5_abort_full");
    checkOutput("t5_data_kept", patch_data, exp_buf);

    // Asynchronous reset at load_cnt 25, then start on the release edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    loadWords(8'h40, 25, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_buf = '0;
    checkIdle("t5_reset");
    checkOutput("t5_reset_done", 256'(load_done), 256'(0));
    checkOutput("t5_reset_data", patch_data, exp_buf);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_restart_busy", 256'(busy), 256'(1));
    checkOutput("t5_restart_cnt", 256'(load_cnt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/patch_loader.md
PATCH_LOADER -- requirements
Module: patch_loader

Interface
REQ-001 Parameters: DW, default 8, literal-word width; NWORDS, fixed 32, words per patch (index 5 bits).
REQ-002 clk  input  1  clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  controller request to begin loading one patch.
REQ-005 abort  input  1  synchronous cancel of the current patch.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DW  upstream literal word.
REQ-008 s_ready  output  1  loader accepts a word this cycle.
REQ-009 patch_valid  output  1  complete patch available downstream.
REQ-010 patch_ready  input  1  downstream accepts the patch.
REQ-011 patch_data  output  NWORDS*DW  packed patch, word k at bits [k*DW+DW-1 : k*DW].
REQ-012 load_cnt  output  5  number of words accepted in the current patch, 0..31.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 load_done  output  1  one-cycle pulse when the 32nd word is accepted.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, FULL; a word transfer SHALL occur only when s_valid and s_ready are both high on a rising edge.
REQ-016 IDLE: s_ready=0, patch_valid=0; start=1 -> LOAD with load_cnt cleared to 0.
REQ-017 LOAD: s_ready=1 (decoded from state only, no dependency on s_valid); each transfer writes s_data to word[load_cnt] and increments load_cnt.
REQ-018 A transfer at load_cnt=31 SHALL write word 31, hold load_cnt at 31 (no wrap), pulse load_done in that same cycle, and move to FULL; s_ready SHALL be 0 from the next cycle, so exactly 32 words are accepted per patch.
REQ-019 s_valid low in LOAD SHALL stall with no state, count or buffer change; gaps of any length are legal.
REQ-020 FULL: patch_valid=1, patch_data stable, s_ready=0; patch_valid and patch_ready both high -> IDLE, load_cnt cleared to 0.
REQ-021 Handoff in FULL with start=1 in the same cycle SHALL go directly to LOAD with load_cnt=0 (no IDLE bubble).
REQ-022 start SHALL be ignored in LOAD, and in FULL when no handoff occurs.
REQ-023 abort=1 SHALL take priority over start, transfers and handoff: next state IDLE, load_cnt=0, no write in that cycle, load_done=0; buffer contents are retained but not presented.
REQ-024 Latency: patch_valid SHALL rise the cycle after the 32nd transfer; minimum patch period is 33 cycles (32 transfers plus 1 FULL cycle).
REQ-025 patch_data SHALL equal the buffer at all times; words not yet rewritten in a new patch hold the previous patch's values.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, load_cnt=0, buffer all-zero, s_ready=0, patch_valid=0, busy=0, load_done=0.
REQ-027 Reset mid-LOAD or mid-FULL SHALL discard the partial or pending patch; no output glitches high during reset.
REQ-028 Release of rst_n SHALL need no further initialisation; start is honoured on the first clock edge after release.

Structure
REQ-029 The state encoding, NWORDS and the load_cnt width SHALL live in the shared accelerator package.
REQ-030 The buffer SHALL be one sub-module, patch_buf: NWORDS x DW registers with write-enable, write-index and a flat read-out; FSM and counter stay in patch_loader.

Verification
REQ-031 Reset, start pulse, then 32 back-to-back words 0x00..0x1F, patch_ready=1 -> load_done in cycle 32, patch_valid for 1 cycle, patch_data word k = k, busy=0 after.
REQ-032 Same 32 words with s_valid toggling every other cycle, patch_ready=0 for 10 cycles -> s_ready=0 and patch_data stable throughout FULL, exactly 32 words consumed, 33rd word not taken.
REQ-033 abort at load_cnt=17 -> IDLE next cycle, load_cnt=0, no patch_valid; a fresh start then loads 32 words normally.
REQ-034 FULL with patch_ready=1 and start=1 in the same cycle -> LOAD next cycle, load_cnt=0, s_ready=1, second patch words 0xA0..0xBF presented correctly.
REQ-035 rst_n asserted at load_cnt=25 -> outputs immediately zero, buffer zero; start ignored while in LOAD; abort and patch_ready both high in FULL -> IDLE via abort.
